uba_intr_arb: RTL and testbench

- Unibus-adapter interrupt arbiter that sits directly downstream of the per-controller interrupt logic (RH11 and similar).
- Collects the level-sensitive device IRQ lines and maps them onto KS10 PI request levels using the UBA PIA fields.
- Runs the CPU interrupt-acknowledge handshake: selects one winning device, returns its vector, and issues the one-cycle IACK pulse that clears that device's interrupt flip-flop.

---
 rtl/uba_intr_arb_if.sv | 29 ++
 rtl/uba_intr_arb.sv | 134 +++++++++++++
 tb/tb_uba_intr_arb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uba_intr_arb_if.sv
// Bus bundle between the Unibus-adapter interrupt arbiter and its surroundings:
// PIA fields, device IRQ/vector lines, CPU INTA handshake and the arbiter outputs.
interface uba_intr_arb_if #(
    parameter int NDEV = 4,
    parameter int VW   = 16
);
    logic [2:0]         ubaPIAH;
    logic [2:0]         ubaPIAL;
    logic [NDEV-1:0]    devIRQ;
    logic [VW*NDEV-1:0] devVECT;
    logic               busINTA;
    logic [2:0]         busPI;
    logic [6:0]         ubaINTR;
    logic [VW-1:0]      ubaVECT;
    logic               ubaACKN;
    logic [NDEV-1:0]    devIACK;

    // The arbiter side.
    modport slave (
        input  ubaPIAH, ubaPIAL, devIRQ, devVECT, busINTA, busPI,
        output ubaINTR, ubaVECT, ubaACKN, devIACK
    );

    // The CPU/device side driving requests and acknowledge cycles.
    modport master (
        output ubaPIAH, ubaPIAL, devIRQ, devVECT, busINTA, busPI,
        input  ubaINTR, ubaVECT, ubaACKN, devIACK
    );
endinterface

// File: rtl/uba_intr_arb.sv
// Unibus-adapter interrupt arbiter: maps device IRQs onto KS10 PI levels and runs
// the INTA handshake, returning the winning vector and a one-cycle IACK pulse.
module uba_intr_arb #(
    parameter int              NDEV  = 4,
    parameter logic [NDEV-1:0] DEVHI = 4'b0011,
    parameter int              VW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    uba_intr_arb_if.slave  bus
);
    localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARB  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            inta_q;
    logic            armed_q, armed_d;
    logic [6:0]      intr_q, intr_d;
    logic [VW-1:0]   vect_q, vect_d;
    logic            ackn_q, ackn_d;
    logic [NDEV-1:0] iack_q, iack_d;

    logic [NDEV-1:0] hi_req, lo_req;
    logic [NDEV-1:0] hi_cand, lo_cand, cand, win_oh;
    logic            hi_match, lo_match, start;
    logic [IW-1:0]   win_idx;
    logic [VW-1:0]   vect_arr [NDEV];

    genvar gi;
    generate
        for (gi = 0; gi < NDEV; gi++) begin : g_vect
            assign vect_arr[gi] = bus.devVECT[VW*gi +: VW];
        end
    endgenerate

    assign hi_req = bus.devIRQ & DEVHI;
    assign lo_req = bus.devIRQ & ~DEVHI;

    // PI request lines; equal PIA fields simply OR onto the same bit.
    always_comb begin
        intr_d = '0;
        if ((|hi_req) && (bus.ubaPIAH != 3'd0))
            intr_d[bus.ubaPIAH - 3'd1] = 1'b1;
        if ((|lo_req) && (bus.ubaPIAL != 3'd0))
            intr_d[bus.ubaPIAL - 3'd1] = 1'b1;
    end

    assign hi_match = (bus.ubaPIAH == bus.busPI) && (bus.busPI != 3'd0);
    assign lo_match = (bus.ubaPIAL == bus.busPI) && (bus.busPI != 3'd0);
    assign hi_cand  = hi_req & {NDEV{hi_match}};
    assign lo_cand  = lo_req & {NDEV{lo_match}};
    assign cand     = (|hi_cand) ? hi_cand : lo_cand;
    // Isolate the lowest set bit: lowest index wins within the chosen group.
    assign win_oh   = cand & (~cand + 1'b1);

    always_comb begin
        win_idx = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (cand[i])
                win_idx = IW'(i);
        end
    end

    // armed_q blocks a cycle start while busINTA has stayed high since reset.
    assign start = bus.busINTA & ~inta_q & armed_q;

    always_comb begin
        state_d = state_q;
        vect_d  = vect_q;
        ackn_d  = ackn_q;
        iack_d  = '0;
        armed_d = armed_q | ~bus.busINTA;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = ARB;
            end
            ARB: begin
                if (|cand) begin
                    vect_d  = vect_arr[win_idx];
                    iack_d  = win_oh;
                    ackn_d  = 1'b1;
                    state_d = ACK;
                end else begin
                    vect_d  = '0;
                    ackn_d  = 1'b0;
                    state_d = DONE;
                end
            end
            ACK: begin
                state_d = DONE;
            end
            DONE: begin
                if (!bus.busINTA) begin
                    state_d = IDLE;
                    ackn_d  = 1'b0;
                    vect_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            inta_q  <= 1'b0;
            armed_q <= 1'b0;
            intr_q  <= '0;
            vect_q  <= '0;
            ackn_q  <= 1'b0;
            iack_q  <= '0;
        end else begin
            state_q <= state_d;
            inta_q  <= bus.busINTA;
            armed_q <= armed_d;
            intr_q  <= intr_d;
            vect_q  <= vect_d;
            ackn_q  <= ackn_d;
            iack_q  <= iack_d;
        end
    end

    assign bus.ubaINTR = intr_q;
    assign bus.ubaVECT = vect_q;
    assign bus.ubaACKN = ackn_q;
    assign bus.devIACK = iack_q;
endmodule

// File: tb/tb_uba_intr_arb.sv
// Bench for uba_intr_arb: directed INTA cycles push expectations into a scoreboard,
// and a monitor summarises each INTA window and compares against it.
module tb_uba_intr_arb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [3:0]  iack;
        logic [15:0] vect;
    } exp_t;

    exp_t exp_q[$];

    uba_intr_arb_if #(.NDEV(4), .VW(16)) bus ();

    uba_intr_arb #(.NDEV(4), .DEVHI(4'b0011), .VW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One complete INTA cycle; the monitor checks what happened inside the window.
    task automatic inta(input logic [2:0] pi, input logic [3:0] ei, input logic [15:0] ev);
        exp_t e;
        e.iack = ei;
        e.vect = ev;
        exp_q.push_back(e);
        bus.busPI   = pi;
        bus.busINTA = 1'b1;
        tick(6);
        bus.busINTA = 1'b0;
        tick(3);
        @(negedge clk);
        chk("ackn_after_release", 32'(bus.ubaACKN), 32'd0);
        chk("vect_after_release", 32'(bus.ubaVECT), 32'd0);
        $display("INTA busPI=%0d expected iack=%b vect=%0o", pi, ei, ev);
    endtask

    // Monitor: accumulate what the DUT presents while busINTA is high.
    initial begin
        logic        in_win;
        logic [3:0]  iack_or;
        int          iack_cnt;
        logic        ackn_seen;
        logic [15:0] vect_or;
        exp_t        e;
        in_win    = 1'b0;
        iack_or   = '0;
        iack_cnt  = 0;
        ackn_seen = 1'b0;
        vect_or   = '0;
        forever begin
            @(negedge clk);
            if (bus.busINTA === 1'b1) begin
                if (!in_win) begin
                    in_win    = 1'b1;
                    iack_or   = '0;
                    iack_cnt  = 0;
                    ackn_seen = 1'b0;
                    vect_or   = '0;
                end
                iack_or = iack_or | bus.devIACK;
                if (bus.devIACK != 4'd0)
                    iack_cnt++;
                if (bus.ubaACKN)
                    ackn_seen = 1'b1;
                vect_or = vect_or | bus.ubaVECT;
            end else if (in_win) begin
                in_win = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("iack_winner", 32'(iack_or), 32'(e.iack));
                    chk("iack_pulse_count", 32'(iack_cnt), (e.iack != 4'd0) ? 32'd1 : 32'd0);
                    chk("ackn_seen", 32'(ackn_seen), (e.iack != 4'd0) ? 32'd1 : 32'd0);
                    chk("vector", 32'(vect_or), 32'(e.vect));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst          = 1'b0;
        bus.ubaPIAH  = 3'd6;
        bus.ubaPIAL  = 3'd4;
        bus.devIRQ   = 4'b1111;
        bus.devVECT  = {16'o300, 16'o224, 16'o254, 16'o100};
        bus.busINTA  = 1'b0;
        bus.busPI    = 3'd0;

        // Reset state
        tick(2);
        @(negedge clk);
        chk("reset_intr", 32'(bus.ubaINTR), 32'd0);
        chk("reset_vect", 32'(bus.ubaVECT), 32'd0);
        chk("reset_ackn", 32'(bus.ubaACKN), 32'd0);
        chk("reset_iack", 32'(bus.devIACK), 32'd0);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        chk("intr_pi6_pi4", 32'(bus.ubaINTR), 32'b0101000);

        // Single high-group request on PI 6
        bus.devIRQ = 4'b0010;
        tick(1);
        @(negedge clk);
        chk("intr_pi6_only", 32'(bus.ubaINTR), 32'b0100000);
        inta(3'd6, 4'b0010, 16'o254);

        // Equal PIA fields: priority between the groups
        bus.ubaPIAH = 3'd5;
        bus.ubaPIAL = 3'd5;
        bus.devIRQ  = 4'b1100;
        tick(1);
        @(negedge clk);
        chk("intr_shared_bit", 32'(bus.ubaINTR), 32'b0010000);
        inta(3'd5, 4'b0100, 16'o224);
        bus.devIRQ = 4'b1110;
        inta(3'd5, 4'b0010, 16'o254);
        bus.devIRQ = 4'b1111;
        inta(3'd5, 4'b0001, 16'o100);

        // Level mismatch gives a passive release; matching levels pick a group
        bus.ubaPIAH = 3'd6;
        bus.ubaPIAL = 3'd4;
        inta(3'd3, 4'b0000, 16'o0);
        inta(3'd4, 4'b0100, 16'o224);
        inta(3'd6, 4'b0001, 16'o100);

        // Disabled high group
        bus.ubaPIAH = 3'd0;
        bus.devIRQ  = 4'b0001;
        tick(1);
        @(negedge clk);
        chk("intr_piah_zero", 32'(bus.ubaINTR), 32'd0);
        inta(3'd0, 4'b0000, 16'o0);
        inta(3'd6, 4'b0000, 16'o0);
        inta(3'd4, 4'b0000, 16'o0);

        // Reset during the ACK cycle
        bus.ubaPIAH = 3'd6;
        begin
            exp_t e;
            e.iack = 4'b0000;
            e.vect = 16'o0;
            exp_q.push_back(e);
        end
        bus.busPI = 3'd6;
        @(posedge clk);
        #1;
        bus.busINTA = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("iack_in_ack_cycle", 32'(bus.devIACK), 32'b0001);
        rst = 1'b0;
        #1;
        chk("async_rst_iack", 32'(bus.devIACK), 32'd0);
        chk("async_rst_ackn", 32'(bus.ubaACKN), 32'd0);
        chk("async_rst_vect", 32'(bus.ubaVECT), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(4);
        @(negedge clk);
        chk("held_inta_no_ackn", 32'(bus.ubaACKN), 32'd0);
        chk("held_inta_no_iack", 32'(bus.devIACK), 32'd0);
        bus.busINTA = 1'b0;
        tick(3);
        $display("INTA held through reset: expected no acknowledge");
        inta(3'd6, 4'b0001, 16'o100);

        tick(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
